// File: rtl/instruction_cache_pkg.sv
// Shared geometry, FSM state encoding and the block word selector
// for the direct-mapped instruction cache.
package instruction_cache_pkg;
  localparam int INDEX_BITS    = 3;
  localparam int TAG_BITS      = 25;
  localparam int OFFSET_BITS   = 2;
  localparam int LINES         = 8;
  localparam int BLOCK_BITS    = 128;
  localparam int BLK_ADDR_BITS = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  function automatic logic [31:0] sel_word(input logic [BLOCK_BITS-1:0] blk,
                                           input logic [OFFSET_BITS-1:0] off);
    return blk[32*off +: 32];
  endfunction
endpackage

// File: rtl/instruction_cache_if.sv
// CPU fetch port and instruction-memory refill port of the cache.
interface instruction_cache_if;
  import instruction_cache_pkg::*;

  logic                     read_enable;
  logic [31:0]              address;
  logic [31:0]              instruction;
  logic                     busywait;
  logic                     mem_read_enable;
  logic [BLK_ADDR_BITS-1:0] mem_address;
  logic [BLOCK_BITS-1:0]    mem_read_data;
  logic                     mem_busywait;

  modport master (
    output read_enable, address, mem_read_data, mem_busywait,
    input  instruction, busywait, mem_read_enable, mem_address
  );

  modport slave (
    input  read_enable, address, mem_read_data, mem_busywait,
    output instruction, busywait, mem_read_enable, mem_address
  );
endinterface

// File: rtl/instruction_cache_fsm.sv
// Refill sequencer: IDLE -> MEM_READ (wait for memory) -> UPDATE -> IDLE.
module icache_fsm
  import instruction_cache_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_read_enable,
  input  logic   i_hit,
  input  logic   i_mem_busywait,
  output state_t o_state,
  output logic   o_busywait,
  output logic   o_mem_read_enable,
  output logic   o_latch,
  output logic   o_fill
);
  state_t r_state;
  state_t w_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    o_busywait        = 1'b0;
    o_mem_read_enable = 1'b0;
    o_latch           = 1'b0;
    o_fill            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_read_enable && !i_hit) begin
          o_busywait = 1'b1;
          o_latch    = 1'b1;
          w_next     = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        o_busywait        = 1'b1;
        o_mem_read_enable = 1'b1;
        if (!i_mem_busywait) begin
          o_fill = 1'b1;
          w_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        o_busywait = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_state = r_state;
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines of 4 words, single
// outstanding block refill; only the valid bits are reset.
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  instruction_cache_if.slave  io_bus
);
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [BLOCK_BITS-1:0] r_data [LINES];
  logic [BLK_ADDR_BITS-1:0] r_blk_addr;
  logic [31:0]           r_instr;

  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [OFFSET_BITS-1:0] w_offset;
  logic [INDEX_BITS-1:0]  w_fill_index;
  logic [TAG_BITS-1:0]    w_fill_tag;
  logic [31:0]            w_word;
  logic                   w_hit;
  logic                   w_latch;
  logic                   w_fill;
  state_t                 w_state;
  logic                   w_unused;

  assign w_tag        = io_bus.address[31:7];
  assign w_index      = io_bus.address[6:4];
  assign w_offset     = io_bus.address[3:2];
  assign w_unused     = ^io_bus.address[1:0];
  assign w_fill_index = r_blk_addr[INDEX_BITS-1:0];
  assign w_fill_tag   = r_blk_addr[BLK_ADDR_BITS-1:INDEX_BITS];

  // Hits are only honoured in IDLE so a stale line can never answer mid-refill.
  assign w_hit  = io_bus.read_enable && (w_state == ST_IDLE) &&
                  r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_word = sel_word(r_data[w_index], w_offset);

  icache_fsm u_fsm (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_read_enable     (io_bus.read_enable),
    .i_hit             (w_hit),
    .i_mem_busywait    (io_bus.mem_busywait),
    .o_state           (w_state),
    .o_busywait        (io_bus.busywait),
    .o_mem_read_enable (io_bus.mem_read_enable),
    .o_latch           (w_latch),
    .o_fill            (w_fill)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= '0;
      r_blk_addr <= '0;
      r_instr    <= '0;
    end else begin
      if (w_latch) r_blk_addr <= io_bus.address[31:4];
      if (w_fill)  r_valid[w_fill_index] <= 1'b1;
      if (w_hit)   r_instr <= w_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= io_bus.mem_read_data;
    end
  end

  assign io_bus.instruction = w_hit ? w_word : r_instr;
  assign io_bus.mem_address = r_blk_addr;
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: reset, refill timing, hits,
// conflict replacement, reset abort and address change during refill.
module tb_instruction_cache;
  localparam int MEM_LATENCY_MAX = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  instruction_cache_if bus ();

  instruction_cache dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] BLK_A = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] BLK_B = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
  localparam logic [127:0] BLK_C = {32'hC0DE_004C, 32'hC0DE_0048, 32'hC0DE_0044, 32'hC0DE_0040};
  localparam logic [127:0] BLK_D = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};

  // Fetch a0 (switching to a1 after the first cycle); memory answers on the
  // n-th MEM_READ cycle of every refill burst.
  task automatic do_fetch(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [127:0] blk, input int n, input logic [31:0] exp_i,
                          input int exp_st, input logic [27:0] ma, input logic [27:0] ma2);
    int stalls = 0;
    int mcyc = 0;
    bit done = 0;
    bit prev_mre = 0;
    bit dropped = 0;
    @(negedge clk);
    bus.read_enable = 1'b1; bus.address = a0;
    bus.mem_busywait = 1'b1; bus.mem_read_data = JUNK;
    for (int c = 0; c < 2 * MEM_LATENCY_MAX + 8 && !done; c++) begin
      #1;
      if (c == 0) begin
        n_checks++;
        if (bus.busywait !== (exp_st > 0)) begin
          n_errors++; $display("FAIL %s_busywait_first: got %b want %b", nm, bus.busywait, exp_st > 0);
        end
        n_checks++;
        if (bus.mem_read_enable !== 1'b0) begin
          n_errors++; $display("FAIL %s_mre_first: got %b want 0", nm, bus.mem_read_enable);
        end
      end
      if (c == 1 && exp_st > 0) begin
        n_checks++;
        if (bus.mem_read_enable !== 1'b1) begin
          n_errors++; $display("FAIL %s_mre_second: got %b want 1", nm, bus.mem_read_enable);
        end
      end
      if (!bus.busywait) begin
        done = 1;
      end else begin
        stalls++;
        if (bus.mem_read_enable) begin
          mcyc++;
          n_checks++;
          if (bus.mem_address !== (dropped ? ma2 : ma)) begin
            n_errors++;
            $display("FAIL %s_mem_address: got %h want %h", nm, bus.mem_address, dropped ? ma2 : ma);
          end
          if (mcyc >= n) begin
            bus.mem_busywait = 1'b0; bus.mem_read_data = blk;
          end
        end else begin
          mcyc = 0;
          if (prev_mre) dropped = 1;
        end
        prev_mre = bus.mem_read_enable;
        @(negedge clk);
        bus.address = a1; bus.mem_busywait = 1'b1; bus.mem_read_data = JUNK;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++; $display("FAIL %s_timeout: got busywait stuck want release", nm);
    end
    n_checks++;
    if (stalls != exp_st) begin
      n_errors++; $display("FAIL %s_stalls: got %0d want %0d", nm, stalls, exp_st);
    end
    n_checks++;
    if (bus.instruction !== exp_i) begin
      n_errors++; $display("FAIL %s_instruction: got %h want %h", nm, bus.instruction, exp_i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.read_enable = 1'b0; bus.address = '0;
    bus.mem_busywait = 1'b1; bus.mem_read_data = JUNK;
    #12;
    n_checks++;
    if (bus.instruction !== 32'h0) begin
      n_errors++; $display("FAIL reset_instruction: got %h want 0", bus.instruction);
    end
    n_checks++;
    if (bus.busywait !== 1'b0) begin
      n_errors++; $display("FAIL reset_busywait: got %b want 0", bus.busywait);
    end
    n_checks++;
    if (bus.mem_read_enable !== 1'b0) begin
      n_errors++; $display("FAIL reset_mre: got %b want 0", bus.mem_read_enable);
    end
    n_checks++;
    if (bus.mem_address !== 28'h0) begin
      n_errors++; $display("FAIL reset_mem_address: got %h want 0", bus.mem_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.busywait !== 1'b0 || bus.mem_read_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got bw=%b mre=%b want 0 0", bus.busywait, bus.mem_read_enable);
    end
  endtask

  task automatic test_first_miss();
    do_fetch("first_miss", 32'h0, 32'h8, BLK_A, 5, 32'h3, 7, 28'h0, 28'h0);
  endtask

  task automatic test_hit_sweep();
    logic [31:0] exp [4];
    exp[0] = 32'h1; exp[1] = 32'h2; exp[2] = 32'h3; exp[3] = 32'h4;
    for (int i = 0; i < 4; i++)
      do_fetch("hit_sweep", 32'(i * 4), 32'(i * 4), JUNK, 1, exp[i], 0, 28'h0, 28'h0);
  endtask

  task automatic test_read_disable();
    @(negedge clk);
    bus.read_enable = 1'b0; bus.address = 32'h0000_0100;
    #1;
    n_checks++;
    if (bus.busywait !== 1'b0 || bus.instruction !== 32'h4) begin
      n_errors++;
      $display("FAIL read_disable: got bw=%b instr=%h want 0 00000004", bus.busywait, bus.instruction);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.mem_read_enable !== 1'b0 || bus.instruction !== 32'h4) begin
      n_errors++;
      $display("FAIL read_disable_hold: got mre=%b instr=%h want 0 00000004",
               bus.mem_read_enable, bus.instruction);
    end
  endtask

  task automatic test_conflict();
    do_fetch("conflict_new", 32'h80, 32'h80, BLK_B, 2, 32'hBBBB_0000, 4, 28'h8, 28'h8);
    do_fetch("conflict_old", 32'h0, 32'h0, BLK_A, 1, 32'h1, 3, 28'h0, 28'h0);
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    bus.read_enable = 1'b1; bus.address = 32'h40; bus.mem_busywait = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.mem_read_enable !== 1'b1 || bus.mem_address !== 28'h4) begin
      n_errors++;
      $display("FAIL abort_pre: got mre=%b addr=%h want 1 0000004", bus.mem_read_enable, bus.mem_address);
    end
    bus.read_enable = 1'b0; bus.mem_busywait = 1'b0; bus.mem_read_data = BLK_C;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_read_enable !== 1'b0 || bus.busywait !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_reset: got mre=%b bw=%b want 0 0", bus.mem_read_enable, bus.busywait);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.mem_busywait = 1'b1; bus.mem_read_data = JUNK;
    do_fetch("abort_refetch", 32'h40, 32'h40, BLK_C, 2, 32'hC0DE_0040, 4, 28'h4, 28'h4);
    do_fetch("abort_line0", 32'h0, 32'h0, BLK_A, 1, 32'h1, 3, 28'h0, 28'h0);
  endtask

  task automatic test_addr_switch();
    do_fetch("addr_switch", 32'h10, 32'h20, BLK_D, 3, 32'hD0D0_0000, 10, 28'h1, 28'h2);
    do_fetch("addr_switch_hit10", 32'h1C, 32'h1C, JUNK, 1, 32'hD0D0_0003, 0, 28'h0, 28'h0);
    do_fetch("addr_switch_hit20", 32'h24, 32'h24, JUNK, 1, 32'hD0D0_0001, 0, 28'h0, 28'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_first_miss();
    test_hit_sweep();
    test_read_disable();
    test_conflict();
    test_reset_mid_refill();
    test_addr_switch();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
